// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle MIPS main controller:
//   - state_t        : controller state encoding
//   - OP_*           : instruction[31:26] opcodes understood by the controller
//   - ALUOP_*        : 2-bit alu_op codes consumed by the ALU control decoder
//   - ALUSRCB_*      : alu_src_b mux selects
//   - PCSRC_*        : pc_source mux selects
//   - ctrl_t         : bundle of every controller output, used for defaults
//   - is_wait_state  : true in states that wait on mem_ready
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ORI_EX   = 4'd11,
        S_IMM_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ORI   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b11;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    localparam int    CTRL_W    = 18;
    localparam ctrl_t CTRL_IDLE = ctrl_t'({CTRL_W{1'b0}});

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on memory. expired_o is high once the count has
// reached WAIT_LIMIT-1; the count then holds until cleared.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   clr_i     in  clear count to zero (has priority over en_i)
//   en_i      in  count one more wait cycle
//   expired_o out count == WAIT_LIMIT-1
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = (count_q == LAST);

    // Next count: clear wins, otherwise increment and saturate at LAST.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CW{1'b0}};
        end else if (en_i && !expired_o) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Wait count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle MIPS main controller. Sequences fetch/decode/execute/memory/
// writeback and drives all datapath enables and mux selects.
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            instruction[31:26] from the instruction register
//   zero              ALU zero flag (consumed by the PC write logic via
//                     pc_write_cond; not used for sequencing)
//   mem_ready         memory completed the current access this cycle
//   pc_write .. pc_source  datapath enables and mux selects
//   illegal_op        one-cycle pulse on an unsupported opcode (in DECODE)
//   mem_timeout       one-cycle pulse when a memory wait expires
//   instr_count       retired-instruction counter, wraps
// All control outputs are forced low while rst_n is low.
// -----------------------------------------------------------------------------
module mc_control_fsm
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_out_s;
    logic             retire_s;
    logic             waiting_s;
    logic             expired_s;
    logic             timeout_s;
    logic             wait_clr_s;
    logic [CNT_W-1:0] instr_count_q;

    // zero only qualifies the PC load outside this block.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    assign waiting_s  = is_wait_state(state_q) && !mem_ready;
    assign timeout_s  = waiting_s && expired_s;
    // A timeout in FETCH stays in FETCH, so it must clear the count explicitly.
    assign wait_clr_s = (state_d != state_q) || timeout_s;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wait_clr_s),
        .en_i      (waiting_s),
        .expired_o (expired_s)
    );

    // Next-state and Moore output decode; a memory timeout overrides everything.
    always_comb begin
        state_d  = state_q;
        ctrl_s   = CTRL_IDLE;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.i_or_d    = 1'b0;
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = ALUSRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALU out.
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = ALUSRCB_IMM_SH2;
                ctrl_s.alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    default: begin
                        ctrl_s.illegal_op = 1'b1;
                        state_d           = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_dst    = 1'b0;
                retire_s          = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_EXECUTE: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_B;
                ctrl_s.alu_op    = ALUOP_RTYPE;
                state_d          = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.mem_to_reg = 1'b0;
                retire_s          = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a     = 1'b1;
                ctrl_s.alu_src_b     = ALUSRCB_B;
                ctrl_s.alu_op        = ALUOP_SUB;
                ctrl_s.pc_write_cond = 1'b1;
                ctrl_s.pc_source     = PCSRC_ALUOUT;
                retire_s             = 1'b1;
                state_d              = S_FETCH;
            end
            S_JUMP: begin
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_source = PCSRC_JUMP;
                retire_s         = 1'b1;
                state_d          = S_FETCH;
            end
            S_ADDI_EX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
                state_d          = S_IMM_WB;
            end
            S_ORI_EX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ORI;
                state_d          = S_IMM_WB;
            end
            S_IMM_WB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b0;
                ctrl_s.mem_to_reg = 1'b0;
                retire_s          = 1'b1;
                state_d           = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // mem_ready has priority: timeout_s is only set when mem_ready is low.
        if (timeout_s) begin
            ctrl_s             = CTRL_IDLE;
            ctrl_s.mem_timeout = 1'b1;
            retire_s           = 1'b0;
            state_d            = S_FETCH;
        end else begin
            ctrl_s.mem_timeout = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_q <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instr_count_q <= instr_count_q + CNT_W'(1);
        end else begin
            instr_count_q <= instr_count_q;
        end
    end

    // Reset masks every control output so nothing fires while rst_n is low.
    assign ctrl_out_s = rst_n ? ctrl_s : CTRL_IDLE;

    assign pc_write      = ctrl_out_s.pc_write;
    assign pc_write_cond = ctrl_out_s.pc_write_cond;
    assign i_or_d        = ctrl_out_s.i_or_d;
    assign mem_read      = ctrl_out_s.mem_read;
    assign mem_write     = ctrl_out_s.mem_write;
    assign ir_write      = ctrl_out_s.ir_write;
    assign mem_to_reg    = ctrl_out_s.mem_to_reg;
    assign reg_dst       = ctrl_out_s.reg_dst;
    assign reg_write     = ctrl_out_s.reg_write;
    assign alu_src_a     = ctrl_out_s.alu_src_a;
    assign alu_src_b     = ctrl_out_s.alu_src_b;
    assign alu_op        = ctrl_out_s.alu_op;
    assign pc_source     = ctrl_out_s.pc_source;
    assign illegal_op    = ctrl_out_s.illegal_op;
    assign mem_timeout   = ctrl_out_s.mem_timeout;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed bench for mc_control_fsm. Each cycle the full control vector is
// compared with a hand-written expected vector for that state.
// Vector layout (MSB first): pc_write, pc_write_cond, i_or_d, mem_read,
// mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
// alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal_op, mem_timeout.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal_op;
    logic        mem_timeout;
    logic [31:0] instr_count;
    logic [17:0] outs_s;

    int checks = 0;
    int errors = 0;

    //                          pcw  pcc  iod  mrd  mwr  irw  m2r  rdst rw   srca srcb   aluop  pcsrc  ill  tmo
    localparam logic [17:0] E_ZERO      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_FETCH_W   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b11,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_FETCH_R   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b11,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b11,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DEC_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b11,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_MEM_ADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEM_RD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEM_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEM_WR    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_EXECUTE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_ALU_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_BRANCH    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0};
    localparam logic [17:0] E_JUMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0};
    localparam logic [17:0] E_ADDI_EX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_ORI_EX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_IMM_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_TIMEOUT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1};

    mc_control_fsm #(
        .WAIT_LIMIT (8),
        .CNT_W      (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout),
        .instr_count   (instr_count)
    );

    assign outs_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op, mem_timeout};

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called 1 unit after a rising edge with inputs already set: check this
    // cycle's outputs mid-cycle, then move to 1 unit after the next edge.
    task automatic step(input string tag, input logic [17:0] exp);
        #2;
        check(tag, {46'd0, outs_s}, {46'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {46'd0, outs_s}, {46'd0, E_ZERO});
        check("rst_cnt", {32'd0, instr_count}, 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type: 4 cycles
        opcode = 6'b000000;
        step("r_fetch", E_FETCH_R);
        step("r_decode", E_DECODE);
        step("r_exec", E_EXECUTE);
        step("r_wb", E_ALU_WB);
        check("r_cnt", {32'd0, instr_count}, 64'd1);

        // lw with 3 wait cycles in MEM_RD: 8 cycles
        opcode = 6'b100011;
        step("lw_fetch", E_FETCH_R);
        step("lw_decode", E_DECODE);
        step("lw_addr", E_MEM_ADDR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_rd_wait", E_MEM_RD);
        mem_ready = 1'b1;
        step("lw_rd", E_MEM_RD);
        step("lw_wb", E_MEM_WB);
        check("lw_cnt", {32'd0, instr_count}, 64'd2);

        // sw: 4 cycles
        opcode = 6'b101011;
        step("sw_fetch", E_FETCH_R);
        step("sw_decode", E_DECODE);
        step("sw_addr", E_MEM_ADDR);
        step("sw_wr", E_MEM_WR);
        check("sw_cnt", {32'd0, instr_count}, 64'd3);

        // beq taken then not taken: same control, both retire
        opcode = 6'b000100;
        zero   = 1'b1;
        step("beq1_fetch", E_FETCH_R);
        step("beq1_decode", E_DECODE);
        step("beq1_br", E_BRANCH);
        check("beq1_cnt", {32'd0, instr_count}, 64'd4);
        zero = 1'b0;
        step("beq0_fetch", E_FETCH_R);
        step("beq0_decode", E_DECODE);
        step("beq0_br", E_BRANCH);
        check("beq0_cnt", {32'd0, instr_count}, 64'd5);

        // j
        opcode = 6'b000010;
        step("j_fetch", E_FETCH_R);
        step("j_decode", E_DECODE);
        step("j_jump", E_JUMP);
        check("j_cnt", {32'd0, instr_count}, 64'd6);

        // addi, ori
        opcode = 6'b001000;
        step("addi_fetch", E_FETCH_R);
        step("addi_decode", E_DECODE);
        step("addi_ex", E_ADDI_EX);
        step("addi_wb", E_IMM_WB);
        check("addi_cnt", {32'd0, instr_count}, 64'd7);
        opcode = 6'b001101;
        step("ori_fetch", E_FETCH_R);
        step("ori_decode", E_DECODE);
        step("ori_ex", E_ORI_EX);
        step("ori_wb", E_IMM_WB);
        check("ori_cnt", {32'd0, instr_count}, 64'd8);

        // illegal opcode: pulse in DECODE, back to FETCH, no retire
        opcode = 6'b111111;
        step("ill_fetch", E_FETCH_R);
        step("ill_decode", E_DEC_ILL);
        check("ill_cnt", {32'd0, instr_count}, 64'd8);

        // fetch timeout: 7 wait cycles, pulse on the 8th, then fetch retries
        mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) step("to_wait", E_FETCH_W);
        step("to_pulse", E_TIMEOUT);
        // retry: mem_ready arrives on the 8th cycle, which wins over timeout
        opcode = 6'b000010;
        for (int i = 0; i < 7; i++) step("to2_wait", E_FETCH_W);
        mem_ready = 1'b1;
        step("to2_ready", E_FETCH_R);
        step("to2_decode", E_DECODE);
        step("to2_jump", E_JUMP);
        check("to_cnt", {32'd0, instr_count}, 64'd9);

        // reset while waiting in MEM_WR
        opcode = 6'b101011;
        step("rs_fetch", E_FETCH_R);
        step("rs_decode", E_DECODE);
        step("rs_addr", E_MEM_ADDR);
        mem_ready = 1'b0;
        #2;
        check("rs_memwr", {46'd0, outs_s}, {46'd0, E_MEM_WR});
        rst_n = 1'b0;
        #1;
        check("rs_outs", {46'd0, outs_s}, {46'd0, E_ZERO});
        check("rs_cnt", {32'd0, instr_count}, 64'd0);
        @(posedge clk);
        #1;
        check("rs_outs_hold", {46'd0, outs_s}, {46'd0, E_ZERO});
        rst_n = 1'b1;
        step("rs_first_fetch", E_FETCH_W);
        mem_ready = 1'b1;
        opcode    = 6'b000100;
        step("rs_fetch2", E_FETCH_R);
        step("rs_decode2", E_DECODE);
        step("rs_br", E_BRANCH);
        check("rs_cnt_after", {32'd0, instr_count}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
